// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master: byte-stream command frames in, single iomem
// transactions out, status (+ read data) bytes back on a byte stream.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data    command byte stream (8 bit)
//   out_valid/out_ready/out_data response byte stream (8 bit)
//   iomem_valid/iomem_ready      bus request / one-cycle completion
//   iomem_wstrb/addr/wdata       bus request payload
//   iomem_rdata                  read data, valid with iomem_ready
module iomem_cmd_master #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP
   } state_t;

   state_t state, state_nxt;

   logic          in_fire, out_fire;
   logic          op_wr, op_rd, op_ok;
   logic          is_write_q;
   logic [3:0]    wstrb_q;
   logic [1:0]    byte_cnt_q;
   logic [2:0]    resp_cnt_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          tmo_hit;
   logic [7:0]    status_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic          resp_last;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   assign op_wr = (in_data[7:4] == 4'h1);
   assign op_rd = (in_data[7:4] == 4'h2);
   assign op_ok = op_rd || (op_wr && (in_data[3:0] != 4'h0));

   assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));

   // Only an OK read carries data bytes after the status byte.
   assign resp_last = (resp_cnt_q == 3'd4) || (status_q != 8'h00)
                      || is_write_q;

   assign iomem_addr  = addr_q;
   assign iomem_wdata = wdata_q;

   always_ff @(posedge clk) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (in_fire) state_nxt = op_ok ? S_ADDR : S_RESP;
         S_ADDR:
            if (in_fire && byte_cnt_q == 2'd3)
               state_nxt = is_write_q ? S_DATA : S_BUS;
         S_DATA:
            if (in_fire && byte_cnt_q == 2'd3) state_nxt = S_BUS;
         S_BUS:
            if (iomem_ready || tmo_hit) state_nxt = S_RESP;
         S_RESP:
            if (out_fire && resp_last) state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = resetn && (state == S_IDLE || state == S_ADDR
                               || state == S_DATA);
      iomem_valid = (state == S_BUS);
      iomem_wstrb = (state == S_BUS && is_write_q) ? wstrb_q : 4'h0;
      out_valid   = (state == S_RESP);
      out_data    = (resp_cnt_q == 3'd0) ? status_q : rdata_q[31:24];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         is_write_q <= 1'b0;
         wstrb_q    <= 4'h0;
         byte_cnt_q <= 2'd0;
         resp_cnt_q <= 3'd0;
         tmo_cnt_q  <= '0;
         status_q   <= 8'h00;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
      end else begin
         if (state == S_IDLE) begin
            byte_cnt_q <= 2'd0;
            if (in_fire) begin
               is_write_q <= op_wr;
               wstrb_q    <= in_data[3:0];
               if (!op_ok) status_q <= 8'hFF;
            end
         end

         // byte_cnt wraps 3->0 on the ADDR->DATA hand-off.
         if (in_fire && state == S_ADDR) begin
            addr_q     <= {addr_q[23:0], in_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end

         if (in_fire && state == S_DATA) begin
            wdata_q    <= {wdata_q[23:0], in_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end

         // Saturates at TIMEOUT-1; the state leaves BUS there anyway.
         if (state != S_BUS)  tmo_cnt_q <= '0;
         else if (!tmo_hit)   tmo_cnt_q <= tmo_cnt_q + TW'(1);

         if (state == S_BUS) begin
            if (iomem_ready) begin
               status_q <= 8'h00;
               if (!is_write_q) rdata_q <= iomem_rdata;
            end else if (tmo_hit) begin
               status_q <= 8'hEE;
            end
         end

         if (state != S_RESP) begin
            resp_cnt_q <= 3'd0;
         end else if (out_fire) begin
            resp_cnt_q <= resp_cnt_q + 3'd1;
            if (resp_cnt_q != 3'd0) rdata_q <= {rdata_q[23:0], 8'h00};
         end
      end
   end

endmodule
